// File: rtl/b002_encoder.sv
// rtl/b002_encoder.sv - IRIG-B002 time-code generator with on-time edge timestamp reports
// Optional feature macro: B002_AUTO_INC_EN (BCD time advances by one second per frame)
module b002_encoder #(
  parameter int BIT_PERIOD = 500000,
  parameter int W0         = 100000,
  parameter int W1         = 250000,
  parameter int WP         = 400000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [63:0]  counter_in,
  input  logic [39:0]  s_time_tdata,
  input  logic         s_time_tvalid,
  output logic         s_time_tready,
  output logic         irig_out,
  output logic         frame_start,
  output logic [103:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         overflow
);

  // Tick counter is wide enough to hold any high width up to a full slot.
  localparam int TW = $clog2(BIT_PERIOD + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [TW-1:0] TW0 = TW'(W0);
  localparam logic [TW-1:0] TW1 = TW'(W1);
  localparam logic [TW-1:0] TWP = TW'(WP);
  localparam logic [6:0] BIT_LAST = 7'd99;

  // Position identifiers: Pr at slot 0, P markers at every slot ending in 9.
  function automatic logic [99:0] f_marker_mask();
    logic [99:0] m;
    m = '0;
    for (int i = 0; i < 100; i++) begin
      if ((i == 0) || ((i % 10) == 9)) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [99:0] MARKER_MASK = f_marker_mask();

`ifdef B002_AUTO_INC_EN
  // Single BCD digit increment; 9 wraps to 0 and the caller handles the carry.
  function automatic logic [3:0] f_dinc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : (d + 4'd1);
  endfunction
`endif

  // Time used for the next frame when nothing new was loaded.
  function automatic logic [39:0] f_next_time(input logic [39:0] t);
    logic [39:0] n;
    n = t;
`ifdef B002_AUTO_INC_EN
    if (t[6:0] != 7'h59) begin
      n[3:0] = f_dinc(t[3:0]);
      if (t[3:0] == 4'd9) n[6:4] = t[6:4] + 3'd1;
    end else begin
      n[6:0] = '0;
      if (t[13:7] != 7'h59) begin
        n[10:7] = f_dinc(t[10:7]);
        if (t[10:7] == 4'd9) n[13:11] = t[13:11] + 3'd1;
      end else begin
        n[13:7] = '0;
        if (t[19:14] != 6'h23) begin
          n[17:14] = f_dinc(t[17:14]);
          if (t[17:14] == 4'd9) n[19:18] = t[19:18] + 2'd1;
        end else begin
          n[19:14] = '0;
          if (t[29:20] != 10'h365) begin
            n[23:20] = f_dinc(t[23:20]);
            if (t[23:20] == 4'd9) begin
              n[27:24] = f_dinc(t[27:24]);
              if (t[27:24] == 4'd9) n[29:28] = t[29:28] + 2'd1;
            end
          end else begin
            // Day 365 rolls to 001; leap days come from a software reload.
            n[29:20] = 10'h001;
            n[33:30] = f_dinc(t[33:30]);
            if (t[33:30] == 4'd9) n[37:34] = f_dinc(t[37:34]);
          end
        end
      end
    end
`endif
    return n;
  endfunction

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic [6:0]    r_bit;
  logic [39:0]   r_frame;
  logic [39:0]   r_pending;
  logic          r_pend;
  logic          r_irig;
  logic          r_frame_start;
  logic          r_overflow;
  logic [103:0]  r_tdata;
  logic          r_tvalid;

  logic [99:0]   w_bits;
  logic [TW-1:0] w_width;
  logic [39:0]   w_frame_next;
  logic          w_load;
  logic          w_latch;

  // The load port is open whenever reset is released.
  assign s_time_tready = resetn;
  assign w_load        = s_time_tvalid & s_time_tready;

  // On-time edge: first tick of slot 0 while running and still enabled.
  assign w_latch = (r_state == S_RUN) && enable && (r_tick == '0) && (r_bit == '0);

  // A pending load wins over the automatic next-second value.
  assign w_frame_next = r_pend ? r_pending : f_next_time(r_frame);

  // Spread the BCD digits of the current frame time over their slots, LSB first.
  always_comb begin
    w_bits        = '0;
    w_bits[4:1]   = r_frame[3:0];
    w_bits[8:6]   = r_frame[6:4];
    w_bits[13:10] = r_frame[10:7];
    w_bits[17:15] = r_frame[13:11];
    w_bits[23:20] = r_frame[17:14];
    w_bits[26:25] = r_frame[19:18];
    w_bits[33:30] = r_frame[23:20];
    w_bits[38:35] = r_frame[27:24];
    w_bits[41:40] = r_frame[29:28];
    w_bits[53:50] = r_frame[33:30];
    w_bits[58:55] = r_frame[37:34];
  end

  // High width of the slot currently being transmitted.
  always_comb begin
    w_width = TW0;
    if (MARKER_MASK[r_bit]) begin
      w_width = TWP;
    end else if (w_bits[r_bit]) begin
      w_width = TW1;
    end
  end

  // Sequencer, frame latch, time load and timestamp report, all registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_tick        <= '0;
      r_bit         <= '0;
      r_frame       <= '0;
      r_pending     <= '0;
      r_pend        <= 1'b0;
      r_irig        <= 1'b0;
      r_frame_start <= 1'b0;
      r_overflow    <= 1'b0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_overflow    <= 1'b0;
      if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_irig <= 1'b0;
          r_tick <= '0;
          r_bit  <= '0;
          if (enable) begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (!enable) begin
            // Abandon the frame; the next enable restarts at slot 0.
            r_state <= S_IDLE;
            r_irig  <= 1'b0;
            r_tick  <= '0;
            r_bit   <= '0;
          end else begin
            r_irig <= (r_tick < w_width);
            if (r_tick == TICK_LAST) begin
              r_tick <= '0;
              r_bit  <= (r_bit == BIT_LAST) ? 7'd0 : (r_bit + 7'd1);
            end else begin
              r_tick <= r_tick + 1'b1;
            end

            if (w_latch) begin
              r_frame       <= w_frame_next;
              r_pend        <= 1'b0;
              r_tdata       <= {counter_in, w_frame_next};
              r_tvalid      <= 1'b1;
              r_frame_start <= 1'b1;
              // An unconsumed report is replaced; flag the loss.
              r_overflow    <= r_tvalid && !m_axis_tready;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // A load in the latch cycle lands after the latch and applies to the next frame.
      if (w_load) begin
        r_pending <= s_time_tdata;
        r_pend    <= 1'b1;
      end
    end
  end

  assign irig_out      = r_irig;
  assign frame_start   = r_frame_start;
  assign overflow      = r_overflow;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tvalid;

endmodule

// File: tb/tb_b002_encoder.sv
// tb/tb_b002_encoder.sv - self-checking bench for b002_encoder with a second-level time model
module tb_b002_encoder;

  localparam int BP    = 100;
  localparam int W0    = 20;
  localparam int W1    = 50;
  localparam int WP    = 80;
  localparam int FRAME = 100 * BP;

  typedef struct packed {
    int sec;
    int mnt;
    int hr;
    int day;
    int yr;
  } tod_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          enable;
  logic [63:0]   counter_in;
  logic [39:0]   s_time_tdata;
  logic          s_time_tvalid;
  logic          s_time_tready;
  logic          irig_out;
  logic          frame_start;
  logic [103:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          overflow;

  logic [63:0]   cyc = '0;
  logic [63:0]   base = '0;
  logic [63:0]   prev_cnt;
  logic [103:0]  last_rep;
  int            meas_w [100];
  int            n_checks = 0;
  int            n_errors = 0;

  tod_t          m_frame;
  tod_t          m_pword;
  logic          m_pend;
  tod_t          m_late_w;
  logic          m_late;

  b002_encoder #(
    .BIT_PERIOD(BP),
    .W0(W0),
    .W1(W1),
    .WP(WP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .counter_in(counter_in),
    .s_time_tdata(s_time_tdata),
    .s_time_tvalid(s_time_tvalid),
    .s_time_tready(s_time_tready),
    .irig_out(irig_out),
    .frame_start(frame_start),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .overflow(overflow)
  );

  // 50 MHz-style clock and a free-running timestamp with a random origin.
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;
  assign counter_in = cyc + base;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] pack(input tod_t t);
    return 40'(t.sec % 10) | (40'(t.sec / 10) << 4) |
           (40'(t.mnt % 10) << 7) | (40'(t.mnt / 10) << 11) |
           (40'(t.hr % 10) << 14) | (40'(t.hr / 10) << 18) |
           (40'(t.day % 10) << 20) | (40'((t.day / 10) % 10) << 24) | (40'(t.day / 100) << 28) |
           (40'(t.yr % 10) << 30) | (40'(t.yr / 10) << 34);
  endfunction

  function automatic tod_t mk(input int s, input int m, input int h, input int d, input int y);
    tod_t t;
    t.sec = s; t.mnt = m; t.hr = h; t.day = d; t.yr = y;
    return t;
  endfunction

  function automatic tod_t rand_tod();
    return mk(int'($urandom_range(59, 0)), int'($urandom_range(59, 0)), int'($urandom_range(23, 0)),
              int'($urandom_range(363, 1)), int'($urandom_range(99, 0)));
  endfunction

  // One second later in plain calendar arithmetic (no leap years).
  function automatic tod_t tod_inc(input tod_t t);
    tod_t r;
    r = t;
`ifdef B002_AUTO_INC_EN
    r.sec = r.sec + 1;
    if (r.sec == 60) begin
      r.sec = 0; r.mnt = r.mnt + 1;
      if (r.mnt == 60) begin
        r.mnt = 0; r.hr = r.hr + 1;
        if (r.hr == 24) begin
          r.hr = 0; r.day = r.day + 1;
          if (r.day > 365) begin
            r.day = 1; r.yr = (r.yr + 1) % 100;
          end
        end
      end
    end
`endif
    return r;
  endfunction

  // Expected high width of slot i for a frame carrying time t.
  function automatic int exp_width(input tod_t t, input int i);
    int pos [11];
    int nb  [11];
    int dv  [11];
    pos = '{1, 6, 10, 15, 20, 25, 30, 35, 40, 50, 55};
    nb  = '{4, 3, 4, 3, 4, 2, 4, 4, 2, 4, 4};
    dv  = '{t.sec % 10, t.sec / 10, t.mnt % 10, t.mnt / 10, t.hr % 10, t.hr / 10,
            t.day % 10, (t.day / 10) % 10, t.day / 100, t.yr % 10, t.yr / 10};
    if ((i == 0) || ((i % 10) == 9)) return WP;
    for (int k = 0; k < 11; k++) begin
      if ((i >= pos[k]) && (i < pos[k] + nb[k])) begin
        return (((dv[k] >> (i - pos[k])) & 1) != 0) ? W1 : W0;
      end
    end
    return W0;
  endfunction

  task automatic model_reset();
    m_frame = mk(0, 0, 0, 0, 0);
    m_pend  = 1'b0;
    m_late  = 1'b0;
  endtask

  task automatic model_latch();
    if (m_pend) begin
      m_frame = m_pword;
      m_pend  = 1'b0;
    end else begin
      m_frame = tod_inc(m_frame);
    end
    if (m_late) begin
      m_pend  = 1'b1;
      m_pword = m_late_w;
      m_late  = 1'b0;
    end
  endtask

  task automatic drive_load(input tod_t w, input logic late);
    s_time_tdata  = pack(w);
    s_time_tvalid = 1'b1;
    if (late) begin
      m_late   = 1'b1;
      m_late_w = w;
    end else begin
      m_pend  = 1'b1;
      m_pword = w;
    end
  endtask

  task automatic check_report(input string tag, input logic exp_ovf);
    check({tag, "_fs"}, frame_start, 1'b1);
    check({tag, "_tdata"}, m_axis_tdata, {prev_cnt, pack(m_frame)});
    check({tag, "_tvalid"}, m_axis_tvalid, 1'b1);
    check({tag, "_tlast"}, m_axis_tlast, 1'b1);
    check({tag, "_ovf"}, overflow, exp_ovf);
    last_rep = m_axis_tdata;
  endtask

  task automatic start_run(input string tag);
    enable = 1'b1;
    @(negedge clk);
    check({tag, "_idle_irig"}, irig_out, 1'b0);
    check({tag, "_idle_fs"}, frame_start, 1'b0);
    prev_cnt = counter_in;
    @(negedge clk);
    check({tag, "_rise"}, irig_out, 1'b1);
  endtask

  // Called on the sample showing frame_start; walks the frame slot by slot.
  task automatic run_frame(input string tag, input logic exp_ovf, input logic rdy,
                           input int la, input tod_t wa, input int lb, input tod_t wb,
                           input int stop_at);
    int   lead;
    int   total;
    int   bad;
    int   stray;
    logic gap;
    lead = 0; total = 0; bad = 0; stray = 0; gap = 1'b0;
    model_latch();
    check_report(tag, exp_ovf);
    m_axis_tready = rdy;
    for (int idx = 0; idx < FRAME; idx++) begin
      s_time_tvalid = 1'b0;
      if ((idx % BP) == 0) begin
        lead = 0; total = 0; gap = 1'b0;
      end
      if (irig_out) begin
        total++;
        if (!gap) lead++;
      end else begin
        gap = 1'b1;
      end
      if ((idx % BP) == BP - 1) begin
        meas_w[idx / BP] = lead;
        if ((lead != exp_width(m_frame, idx / BP)) || (total != lead)) bad++;
      end
      if ((idx > 0) && (frame_start || overflow)) stray++;
      if (idx == 1) check({tag, "_tvalid_hold"}, m_axis_tvalid, !rdy);
      if (idx == la) drive_load(wa, idx == FRAME - 1);
      if (idx == lb) drive_load(wb, idx == FRAME - 1);
      if (idx == stop_at) begin
        enable = 1'b0;
        @(negedge clk);
        break;
      end
      prev_cnt = counter_in;
      @(negedge clk);
    end
    s_time_tvalid = 1'b0;
    check({tag, "_slots"}, bad, 0);
    check({tag, "_stray"}, stray, 0);
  endtask

  initial begin
    tod_t t1;
    tod_t tx;
    tod_t troll;
    tod_t t4;
    tod_t tnone;
    logic [39:0] roll_next;
    logic [39:0] f4_time;
    logic [39:0] post_time;

    t1    = mk(37, 12, 23, 123, 24);
    troll = mk(59, 59, 23, 365, 99);
    tx    = rand_tod();
    t4    = rand_tod();
    tnone = mk(0, 0, 0, 0, 0);
`ifdef B002_AUTO_INC_EN
    roll_next = 40'h00_0010_0000;
    f4_time   = 40'h00_0010_0001;
    post_time = 40'h00_0000_0001;
`else
    roll_next = 40'h26_7658_ECD9;
    f4_time   = 40'h26_7658_ECD9;
    post_time = 40'h00_0000_0000;
`endif

    base          = {$urandom, $urandom};
    resetn        = 1'b0;
    enable        = 1'b1;
    s_time_tvalid = 1'b1;
    s_time_tdata  = {$urandom, $urandom};
    m_axis_tready = 1'b0;
    model_reset();

    // Reset dominates a pending load and enable.
    repeat (3) @(negedge clk);
    check("rst_irig", irig_out, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 104'd0);
    check("rst_tready", s_time_tready, 1'b0);

    resetn        = 1'b1;
    enable        = 1'b0;
    s_time_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("idle_tready", s_time_tready, 1'b1);
    check("idle_irig", irig_out, 1'b0);

    // Frame 1: known time, then two loads of which only the last survives.
    s_time_tdata  = pack(t1);
    s_time_tvalid = 1'b1;
    m_pend  = 1'b1;
    m_pword = t1;
    @(negedge clk);
    s_time_tvalid = 1'b0;
    start_run("f1");
    run_frame("f1", 1'b0, 1'b1, int'($urandom_range(4000, 100)), tx,
              int'($urandom_range(9000, 5000)), troll, -1);
    check("f1_time", last_rep[39:0], 40'h09_1238_C937);
    check("f1_w0", meas_w[0], 80);
    check("f1_w1", meas_w[1], 50);
    check("f1_w2", meas_w[2], 50);
    check("f1_w3", meas_w[3], 50);
    check("f1_w4", meas_w[4], 20);
    check("f1_w9", meas_w[9], 80);
    check("f1_w20", meas_w[20], 50);

    // Frame 2 carries the rollover time; its report is left unconsumed.
    run_frame("f2", 1'b0, 1'b0, -1, tnone, -1, tnone, -1);
    check("f2_time", last_rep[39:0], 40'h26_7658_ECD9);

    // Frame 3 overwrites the report; load a new time exactly in the next latch cycle.
    run_frame("f3", 1'b1, 1'b1, FRAME - 1, t4, -1, tnone, -1);
    check("f3_time", last_rep[39:0], roll_next);

    // Frame 4 still uses the old time; abort it at bit 45 tick 30.
    run_frame("f4", 1'b0, 1'b1, -1, tnone, -1, tnone, 45 * BP + 29);
    check("f4_time", last_rep[39:0], f4_time);
    check("dis_irig", irig_out, 1'b0);
    repeat (3) @(negedge clk);
    check("dis_hold_irig", irig_out, 1'b0);
    check("dis_hold_fs", frame_start, 1'b0);

    // Restart picks up the pending word; then abort inside the Pr marker.
    start_run("re1");
    run_frame("re1", 1'b0, 1'b1, -1, tnone, -1, tnone, 9);
    check("dis2_irig", irig_out, 1'b0);

    // Restart with nothing pending, run a full frame and check the next report.
    start_run("re2");
    run_frame("f5", 1'b0, 1'b1, -1, tnone, -1, tnone, -1);
    model_latch();
    check_report("f6", 1'b0);

    // Reset in the middle of a marker returns everything to reset values.
    m_axis_tready = 1'b0;
    repeat (37) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("mrst_irig", irig_out, 1'b0);
    check("mrst_tvalid", m_axis_tvalid, 1'b0);
    check("mrst_tdata", m_axis_tdata, 104'd0);
    check("mrst_tready", s_time_tready, 1'b0);
    resetn        = 1'b1;
    enable        = 1'b0;
    m_axis_tready = 1'b1;
    model_reset();
    @(negedge clk);
    start_run("post");
    model_latch();
    check_report("post", 1'b0);
    check("post_time", last_rep[39:0], post_time);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/b002_encoder.md
# b002_encoder

IRIG-B002 time-code generator: the transmit-side counterpart of the IRIG-B002 decoder, sharing its 50 MHz clock, 64-bit free-running counter and pulse-width conventions. It serialises a BCD time-of-year into 100-bit, 1 s frames of pulse-width-coded symbols on `irig_out`. Each on-time edge (leading edge of the Pr reference marker) is timestamped with `counter_in` and reported on an AXI-Stream port.

## Interface
- `BIT_PERIOD`, 500000: clocks per bit slot (10 ms at 50 MHz).
- `W0`, 100000: high width of a 0 symbol (2 ms).
- `W1`, 250000: high width of a 1 symbol (5 ms).
- `WP`, 400000: high width of a P/Pr marker (8 ms).
- `clk` in 1: system clock, 50 MHz.
- `resetn` in 1: reset, synchronous, active-low.
- `enable` in 1: run; low forces idle.
- `counter_in` in 64: free-running timestamp counter.
- `s_time_tdata` in 40: BCD time. [6:0] sec, [13:7] min, [19:14] hour, [29:20] day-of-year, [37:30] year (2-digit), [39:38] ignored.
- `s_time_tvalid` in 1, `s_time_tready` out 1: time load handshake.
- `irig_out` out 1: IRIG-B002 waveform, registered.
- `frame_start` out 1: one-cycle pulse on each on-time edge.
- `m_axis_tdata` out 104: {edge timestamp[63:0], frame time[39:0]}.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1 (= tvalid).
- `overflow` out 1: one-cycle pulse when an unconsumed report is overwritten.

## Operation
- States: IDLE, RUN. IDLE→RUN when `enable`=1; RUN→IDLE when `enable`=0 (any bit, any tick). In IDLE: tick=0, bit=0, `irig_out`=0.
- RUN: tick counts 0..BIT_PERIOD-1, wraps and advances bit 0..99; bit 99 wraps to 0.
- Symbol: `irig_out`=1 while tick < width(bit), else 0. Width is WP for bit 0 and bits 9,19,…,99. For other bits it is W1 if the frame bit is 1, else W0.
- Bit map (BCD, LSB first):
  - sec units 1–4, tens 6–8.
  - min units 10–13, tens 15–17.
  - hour units 20–23, tens 25–26.
  - day units 30–33, tens 35–38, hundreds 40–41.
  - year units 50–53, tens 55–58.
  - All other non-marker bits are 0.
- Load: `s_time_tready`=1 whenever not in reset. An accepted word goes into a pending register and sets a pending flag; the last write wins. Inputs are not range-checked.
- Frame latch: at bit=0, tick=0 the frame register takes the pending word if the flag is set, then clears the flag; otherwise it takes the auto-increment result (see Configuration). A load accepted in the same cycle as the latch applies to the next frame.
- Report: at bit=0, tick=0, capture {counter_in, frame time} into the output register, set `m_axis_tvalid`, pulse `frame_start`. `tvalid` holds until `tready`. If a new frame starts while `tvalid`=1, the data is overwritten, `tvalid` stays 1 and `overflow` pulses.
- Before any load, the frame time is all zero.

## Timing
- Reset values:
  - `irig_out`, `frame_start`, `overflow`, `m_axis_tvalid`, `m_axis_tlast` = 0.
  - `m_axis_tdata` = 0; `s_time_tready` = 0 during reset.
  - state IDLE; pending flag clear; frame time 0.
- `enable` sampled high at edge k: `irig_out` and `frame_start` rise at edge k+1. `counter_in` is sampled at edge k+1.
- `irig_out` is high for exactly width(bit) cycles in each slot. Slot length is exactly BIT_PERIOD cycles and frame length 100·BIT_PERIOD cycles, with no drift.
- `enable` dropping mid-frame: `irig_out`=0 at the next edge. Re-enabling restarts at bit 0, tick 0; the pending word and frame time are retained.
- Reset mid-frame returns everything to reset values at that edge.

## Configuration
- `B002_AUTO_INC_EN` defined: with no pending load, the frame time advances by 1 s per frame in BCD.
  - sec 59→00 carries to min; min 59→00 carries to hour; hour 23→00 carries to day.
  - day 365→001 carries to year; year 99→00. Leap years are handled by software reload.
- `B002_AUTO_INC_EN` undefined: with no pending load, the previous frame time is repeated unchanged.

## Test plan
Bench parameters: BIT_PERIOD=100, W0=20, W1=50, WP=80.
- Load sec=0x37, min=0x12, hour=0x23, day=0x123, year=0x24, then enable. Bit widths in frame 1: bit0 80, bits 1–4 = 50,50,50,20 (units 7), bit9 80, bit20 50 (hour units 3). Frame length is 10000 cycles.
- Enable with no load; `m_axis_tready`=1. `frame_start` every 10000 cycles; tdata timestamp equals `counter_in` at each `irig_out` rise; tlast=tvalid.
- `B002_AUTO_INC_EN` on, load 23:59:59 day 365 year 99. Next frame encodes 00:00:00 day 001 year 00. With the macro off, the second frame is identical to the first.
- Hold `m_axis_tready`=0 for two frames. `overflow` pulses once at the second frame start; data is from the second frame.
- Deassert `enable` at bit 45, tick 30. `irig_out`=0 on the next edge. Re-enable: `irig_out` rises one cycle later with a Pr marker of 80 cycles.
- Load in the exact latch cycle: the current frame uses the old time, the next frame uses the new one. Two loads before a frame: only the last is encoded.
